// File: rtl/ftdi_pkg.sv
// Shared definitions for the FT232H pixel parser: sync header defaults,
// parser state encoding and pixel width.
package ftdi_pkg;

    localparam logic [7:0] SYNC_A_DEF = 8'hA5;
    localparam logic [7:0] SYNC_B_DEF = 8'h5A;
    localparam int         PIXEL_W    = 24;

    typedef enum logic [1:0] {
        HUNT_A = 2'd0,
        HUNT_B = 2'd1,
        PIXEL  = 2'd2,
        CSUM   = 2'd3
    } state_e;

endpackage

// File: rtl/ftdi_pixel_parser.sv
// Locks onto the A5/5A frame header and packs the following bytes into RGB pixel writes.
// Optional trailing frame checksum byte: define PIXEL_PARSER_CHECKSUM_EN.
//
// state  | meaning
// HUNT_A | waiting for first header byte
// HUNT_B | first header byte seen, waiting for second
// PIXEL  | collecting R,G,B triplets and writing pixels
// CSUM   | waiting for the frame checksum byte (checksum build only)
module ftdi_pixel_parser
    import ftdi_pkg::*;
#(
    parameter int         NUM_PIXELS = 4096,
    parameter int         ADDR_W     = 12,
    parameter logic [7:0] SYNC_A     = SYNC_A_DEF,
    parameter logic [7:0] SYNC_B     = SYNC_B_DEF
) (
    input  logic               clk_60,
    input  logic               rst,
    input  logic [7:0]         byte_data,
    input  logic               byte_valid,
    output logic               px_we,
    output logic [ADDR_W-1:0]  px_addr,
    output logic [PIXEL_W-1:0] px_data,
    output logic               frame_done,
    output logic               frame_err,
    output logic               busy
);

    localparam logic [ADDR_W-1:0] LAST_PX = ADDR_W'(NUM_PIXELS - 1);

    state_e               state_q, state_d;
    logic [1:0]           bcnt_q, bcnt_d;
    logic [ADDR_W-1:0]    pcnt_q, pcnt_d;
    logic [7:0]           r_q, r_d;
    logic [7:0]           g_q, g_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [PIXEL_W-1:0]   data_q, data_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
`ifdef PIXEL_PARSER_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
    logic                 err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        pcnt_d  = pcnt_q;
        r_d     = r_q;
        g_d     = g_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
`ifdef PIXEL_PARSER_CHECKSUM_EN
        csum_d  = csum_q;
        err_d   = 1'b0;
`endif
        if (byte_valid) begin
            case (state_q)
                HUNT_A: begin
                    if (byte_data == SYNC_A) state_d = HUNT_B;
                end
                HUNT_B: begin
                    if (byte_data == SYNC_B) begin
                        state_d = PIXEL;
                        bcnt_d  = 2'd0;
                        pcnt_d  = '0;
`ifdef PIXEL_PARSER_CHECKSUM_EN
                        csum_d  = 8'd0;
`endif
                    end else if (byte_data != SYNC_A) begin
                        state_d = HUNT_A;
                    end
                end
                PIXEL: begin
`ifdef PIXEL_PARSER_CHECKSUM_EN
                    csum_d = csum_q + byte_data;
`endif
                    case (bcnt_q)
                        2'd0: begin
                            r_d    = byte_data;
                            bcnt_d = 2'd1;
                        end
                        2'd1: begin
                            g_d    = byte_data;
                            bcnt_d = 2'd2;
                        end
                        default: begin
                            bcnt_d = 2'd0;
                            we_d   = 1'b1;
                            addr_d = pcnt_q;
                            data_d = {r_q, g_q, byte_data};
                            if (pcnt_q == LAST_PX) begin
                                pcnt_d = '0;
`ifdef PIXEL_PARSER_CHECKSUM_EN
                                state_d = CSUM;
`else
                                state_d = HUNT_A;
                                done_d  = 1'b1;
`endif
                            end else begin
                                pcnt_d = pcnt_q + ADDR_W'(1);
                            end
                        end
                    endcase
                end
`ifdef PIXEL_PARSER_CHECKSUM_EN
                CSUM: begin
                    // Pixels are already in the buffer; the pulse decides whether it is swapped in.
                    if (byte_data == csum_q) done_d = 1'b1;
                    else                     err_d  = 1'b1;
                    state_d = HUNT_A;
                end
`endif
                default: state_d = HUNT_A;
            endcase
        end
        busy_d = (state_d == PIXEL) || (state_d == CSUM);
    end

    always_ff @(posedge clk_60) begin
        if (rst) begin
            state_q <= HUNT_A;
            bcnt_q  <= 2'd0;
            pcnt_q  <= '0;
            r_q     <= 8'd0;
            g_q     <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PIXEL_PARSER_CHECKSUM_EN
            csum_q  <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            pcnt_q  <= pcnt_d;
            r_q     <= r_d;
            g_q     <= g_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef PIXEL_PARSER_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

    assign px_we      = we_q;
    assign px_addr    = addr_q;
    assign px_data    = data_q;
    assign frame_done = done_q;
    assign busy       = busy_q;
`ifdef PIXEL_PARSER_CHECKSUM_EN
    assign frame_err  = err_q;
`else
    assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ftdi_pixel_parser.sv
// Bench for ftdi_pixel_parser (NUM_PIXELS=4): byte-level reference model checked every cycle,
// plus literal expectations on the captured pixel writes.
module tb_ftdi_pixel_parser;

    localparam int NP = 4;
    localparam int AW = 2;

    logic          clk_60 = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_valid = 1'b0;
    logic          px_we;
    logic [AW-1:0] px_addr;
    logic [23:0]   px_data;
    logic          frame_done;
    logic          frame_err;
    logic          busy;

    ftdi_pixel_parser #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
        .clk_60     (clk_60),
        .rst        (rst),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .px_we      (px_we),
        .px_addr    (px_addr),
        .px_data    (px_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk_60 = ~clk_60;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    // Reference model: tracks the byte stream in terms of "saw A5 last", "inside payload",
    // "awaiting checksum", the partially collected triplet and the running byte sum.
    bit          m_prev_a5 = 0;
    bit          m_in_frame = 0;
    bit          m_in_csum = 0;
    logic [7:0]  m_trip [3];
    int          m_n = 0;
    int          m_idx = 0;
    int          m_sum = 0;

    logic        exp_we = 0;
    int          exp_addr = 0;
    logic [23:0] exp_data = 0;
    logic        exp_done = 0;
    logic        exp_err = 0;
    logic        exp_busy = 0;

    task automatic model_step();
        if (rst) begin
            m_prev_a5 = 0; m_in_frame = 0; m_in_csum = 0; m_n = 0; m_idx = 0; m_sum = 0;
            exp_we = 0; exp_addr = 0; exp_data = 0; exp_done = 0; exp_err = 0; exp_busy = 0;
            return;
        end
        exp_we = 0; exp_done = 0; exp_err = 0;
        if (byte_valid !== 1'b1) return;
        if (m_in_frame) begin
            m_trip[m_n] = byte_data;
            m_n++;
            m_sum = (m_sum + int'(byte_data)) % 256;
            if (m_n == 3) begin
                m_n = 0;
                exp_we = 1;
                exp_addr = m_idx;
                exp_data = {m_trip[0], m_trip[1], m_trip[2]};
                if (m_idx == NP - 1) begin
                    m_idx = 0;
                    m_in_frame = 0;
`ifdef PIXEL_PARSER_CHECKSUM_EN
                    m_in_csum = 1;
`else
                    exp_done = 1;
`endif
                end else begin
                    m_idx++;
                end
            end
        end else if (m_in_csum) begin
            if (int'(byte_data) == m_sum) exp_done = 1;
            else                          exp_err = 1;
            m_in_csum = 0;
            m_prev_a5 = 0;
        end else begin
            if (m_prev_a5 && byte_data == 8'h5A) begin
                m_in_frame = 1; m_n = 0; m_idx = 0; m_sum = 0; m_prev_a5 = 0;
            end else begin
                m_prev_a5 = (byte_data == 8'hA5);
            end
        end
        exp_busy = m_in_frame || m_in_csum;
    endtask

    int          q_addr [$];
    logic [23:0] q_data [$];
    bit          q_done [$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    bit          started = 0;

    always @(negedge clk_60) begin
        if (started) begin
            chk("px_we", 32'(px_we), 32'(exp_we));
            chk("px_addr", 32'(px_addr), 32'(exp_addr));
            chk("px_data", 32'(px_data), 32'(exp_data));
            chk("frame_done", 32'(frame_done), 32'(exp_done));
            chk("frame_err", 32'(frame_err), 32'(exp_err));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (px_we === 1'b1) begin
                q_addr.push_back(int'(px_addr));
                q_data.push_back(px_data);
                q_done.push_back(frame_done === 1'b1);
            end
            if (frame_done === 1'b1) done_cnt++;
            if (frame_err === 1'b1) err_cnt++;
        end
        model_step();
    end

    task automatic clear_log();
        q_addr.delete(); q_data.delete(); q_done.delete();
        done_cnt = 0; err_cnt = 0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        byte_data = b;
        byte_valid = 1'b1;
        @(posedge clk_60); #1;
        byte_valid = 1'b0;
        byte_data = 8'($urandom);
        repeat (gap) begin @(posedge clk_60); #1; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_60); #1; end
    endtask

    task automatic header();
        send(8'hA5, 0);
        send(8'h5A, 0);
    endtask

    // Sends 12 payload bytes; checksum build appends the byte sum plus csum_bias.
    task automatic payload(input logic [7:0] p [12], input int gap, input int csum_bias);
        int s = 0;
        for (int i = 0; i < 12; i++) begin
            send(p[i], gap);
            s += int'(p[i]);
        end
`ifdef PIXEL_PARSER_CHECKSUM_EN
        send(8'(s + csum_bias), gap);
`else
        if (csum_bias != 0) idle(0);
`endif
    endtask

    task automatic chk_writes(input string name, input logic [23:0] lit [4]);
        chk({name, "_nwr"}, 32'(q_data.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk({name, "_addr"}, (i < q_addr.size()) ? 32'(q_addr[i]) : 32'hDEAD, 32'(i));
            chk({name, "_data"}, (i < q_data.size()) ? 32'(q_data[i]) : 32'hDEAD, 32'(lit[i]));
        end
        chk({name, "_done"}, 32'(done_cnt), 32'd1);
`ifndef PIXEL_PARSER_CHECKSUM_EN
        chk({name, "_done_on_last"}, (q_done.size() == 4) ? 32'(q_done[3]) : 32'hDEAD, 32'd1);
`endif
    endtask

    initial begin
        logic [7:0]  p_inc [12];
        logic [7:0]  p_t2 [12];
        logic [7:0]  p_hdr [12];
        logic [23:0] lit [4];
        logic [23:0] save_d [$];
        int          save_a [$];

        for (int i = 0; i < 12; i++) begin
            p_inc[i] = 8'(i + 1);
            p_t2[i]  = 8'(8'h10 + i);
        end
        p_hdr[0] = 8'hA5; p_hdr[1] = 8'h5A; p_hdr[2] = 8'h00;
        for (int i = 3; i < 12; i++) p_hdr[i] = 8'(i - 2);

        rst = 1'b1;
        repeat (2) @(posedge clk_60);
        #1;
        started = 1;
        chk("rst_we", 32'(px_we), 32'd0);
        chk("rst_addr", 32'(px_addr), 32'd0);
        chk("rst_data", 32'(px_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle(2);

        // basic frame
        clear_log();
        header();
        chk("busy_after_hdr", 32'(busy), 32'd1);
        payload(p_inc, 0, 0);
        idle(3);
        lit = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
        chk_writes("t1", lit);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // garbage and repeated A5 before the header
        clear_log();
        send(8'h00, 0); send(8'hA5, 0);
        header();
        payload(p_t2, 0, 0);
        idle(3);
        lit = '{24'h101112, 24'h131415, 24'h161718, 24'h191A1B};
        chk_writes("t2", lit);

        // broken header: no lock until a proper A5 5A
        clear_log();
        send(8'hA5, 0); send(8'h33, 0); send(8'h5A, 0);
        for (int i = 0; i < 12; i++) send(8'(8'h21 + i), 0);
        idle(2);
        chk("t3_nolock", 32'(q_data.size()), 32'd0);
        header();
        payload(p_inc, 0, 0);
        idle(3);
        lit = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
        chk_writes("t3", lit);

        // header bytes inside payload are data; gapped stream must match
        clear_log();
        header();
        payload(p_hdr, 0, 0);
        idle(3);
        lit = '{24'hA55A00, 24'h010203, 24'h040506, 24'h070809};
        chk_writes("t4", lit);
        save_a = q_addr;
        save_d = q_data;
        clear_log();
        header();
        payload(p_hdr, 3, 0);
        idle(3);
        chk("t4_gap_nwr", 32'(q_data.size()), 32'(save_d.size()));
        for (int i = 0; i < 4; i++) begin
            chk("t4_gap_addr", (i < q_addr.size()) ? 32'(q_addr[i]) : 32'hDEAD, 32'(save_a[i]));
            chk("t4_gap_data", (i < q_data.size()) ? 32'(q_data[i]) : 32'hDEAD, 32'(save_d[i]));
        end

        // reset mid-frame
        clear_log();
        header();
        for (int i = 0; i < 5; i++) send(8'(i + 1), 0);
        chk("t5_pre_rst_wr", 32'(q_data.size()), 32'd1);
        clear_log();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) send(8'(8'h40 + i), 0);
        idle(2);
        chk("t5_no_wr", 32'(q_data.size()), 32'd0);
        chk("t5_addr0", 32'(px_addr), 32'd0);
        chk("t5_data0", 32'(px_data), 32'd0);
        chk("t5_busy0", 32'(busy), 32'd0);
        header();
        payload(p_inc, 0, 0);
        idle(3);
        lit = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
        chk_writes("t5", lit);

`ifdef PIXEL_PARSER_CHECKSUM_EN
        // good checksum 4E then bad checksum 4F
        clear_log();
        header();
        for (int i = 0; i < 12; i++) send(p_inc[i], 0);
        chk("cs_busy_wait", 32'(busy), 32'd1);
        send(8'h4E, 0);
        chk("cs_good_done", 32'(frame_done), 32'd1);
        chk("cs_good_err", 32'(frame_err), 32'd0);
        idle(2);
        clear_log();
        header();
        for (int i = 0; i < 12; i++) send(p_inc[i], 0);
        send(8'h4F, 0);
        chk("cs_bad_err", 32'(frame_err), 32'd1);
        idle(2);
        chk("cs_bad_errcnt", 32'(err_cnt), 32'd1);
        chk("cs_bad_nodone", 32'(done_cnt), 32'd0);
        chk("cs_bad_nwr", 32'(q_data.size()), 32'd4);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
